// File: rtl/reg_scoreboard_pkg.sv
// Shared defaults for the register-hazard scoreboard: address width, register
// count, counter width and the hard-wired zero register address.
package reg_scoreboard_pkg;

  localparam int SCB_REG_ADDR_W = 5;
  localparam int SCB_REG_NUM    = 32;
  localparam int SCB_CNT_W      = 2;
  localparam int SCB_R0_ADDR    = 0;

endpackage

// File: rtl/scb_counter.sv
// One per-register outstanding-write counter: saturating up/down with a
// dominant synchronous clear, plus underflow/overflow event pulses.
module scb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SCB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_nonzero,
  output logic             o_underflow,
  output logic             o_overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic             w_dec_ok;
  logic             w_sat;

  assign w_dec_ok = i_dec && (r_count != '0);
  assign w_sat    = (r_count == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_dec_ok) begin
      if (!w_sat) r_count <= r_count + 1'b1;
    end else if (!i_inc && w_dec_ok) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A clear discards the same-cycle events, so they raise no error either.
  assign o_underflow = !i_clr && i_dec && (r_count == '0);
  assign o_overflow  = !i_clr && i_inc && !w_dec_ok && w_sat;
  assign o_count     = r_count;
  assign o_nonzero   = (r_count != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for ID: per-register in-flight write counts,
// combinational RAW/WAW stall, flush and sticky error flags.
// Optional macro SCB_WB_BYPASS_EN: a read of a register whose last pending
// write retires this cycle does not stall (the datapath forwards it).
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = SCB_REG_ADDR_W,
  parameter int REG_NUM    = SCB_REG_NUM,
  parameter int READ_PORTS = 2,
  parameter int CNT_W      = SCB_CNT_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             issue_valid,
  input  logic [READ_PORTS-1:0]            issue_read_en,
  input  logic [READ_PORTS*REG_ADDR_W-1:0] issue_read_addr,
  input  logic                             issue_write_en,
  input  logic [REG_ADDR_W-1:0]            issue_write_addr,
  input  logic                             wb_en,
  input  logic [REG_ADDR_W-1:0]            wb_addr,
  input  logic                             flush,
  output logic                             stall,
  output logic                             issue_fire,
  output logic [REG_NUM-1:0]               pending_mask,
  output logic                             err_underflow,
  output logic                             err_overflow
);

  localparam int                      ADDR_SPACE = 2**REG_ADDR_W;
  localparam logic [CNT_W-1:0]        CNT_MAX    = '1;
  localparam logic [REG_ADDR_W-1:0]   R0         = REG_ADDR_W'(SCB_R0_ADDR);

  // Untracked slots (r0 and addresses >= REG_NUM) read as a constant zero count.
  logic [CNT_W-1:0]      w_cnt [ADDR_SPACE];
  logic [ADDR_SPACE-1:0] w_nonzero;
  logic [ADDR_SPACE-1:0] w_uf;
  logic [ADDR_SPACE-1:0] w_of;
  logic [READ_PORTS-1:0] w_rd_hazard;
  logic                  w_waw_sat;
  logic                  w_stall;
  logic                  w_fire;
  logic                  r_err_underflow;
  logic                  r_err_overflow;

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic [REG_ADDR_W-1:0] w_addr;
    logic                  w_busy;
    logic                  w_bypass;

    assign w_addr = issue_read_addr[i*REG_ADDR_W +: REG_ADDR_W];
    assign w_busy = issue_read_en[i] && (w_addr != R0) && (w_cnt[w_addr] != '0);
`ifdef SCB_WB_BYPASS_EN
    assign w_bypass = wb_en && (wb_addr == w_addr) && (w_cnt[w_addr] == CNT_W'(1));
`else
    assign w_bypass = 1'b0;
`endif
    assign w_rd_hazard[i] = w_busy && !w_bypass;
  end

  assign w_waw_sat = issue_write_en && (issue_write_addr != R0) &&
                     (w_cnt[issue_write_addr] == CNT_MAX);
  assign w_stall   = issue_valid && ((|w_rd_hazard) || w_waw_sat);
  assign w_fire    = issue_valid && !w_stall;

  for (genvar r = 0; r < ADDR_SPACE; r++) begin : g_reg
    if (r == SCB_R0_ADDR || r >= REG_NUM) begin : g_untracked
      assign w_cnt[r]     = '0;
      assign w_nonzero[r] = 1'b0;
      assign w_uf[r]      = 1'b0;
      assign w_of[r]      = 1'b0;
    end else begin : g_tracked
      scb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (flush),
        .i_inc       (w_fire && issue_write_en && (issue_write_addr == REG_ADDR_W'(r))),
        .i_dec       (wb_en && (wb_addr == REG_ADDR_W'(r))),
        .o_count     (w_cnt[r]),
        .o_nonzero   (w_nonzero[r]),
        .o_underflow (w_uf[r]),
        .o_overflow  (w_of[r])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_underflow <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      if (|w_uf) r_err_underflow <= 1'b1;
      if (|w_of) r_err_overflow  <= 1'b1;
    end
  end

  assign stall         = w_stall;
  assign issue_fire    = w_fire;
  assign pending_mask  = w_nonzero[REG_NUM-1:0];
  assign err_underflow = r_err_underflow;
  assign err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus a randomized
// run against a per-register integer count model.
module tb_reg_scoreboard;

  localparam int NREG = 32;
  localparam int MAXC = 3;
`ifdef SCB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [1:0]  issue_read_en;
  logic [9:0]  issue_read_addr;
  logic        issue_write_en;
  logic [4:0]  issue_write_addr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic        flush;
  logic        stall;
  logic        issue_fire;
  logic [31:0] pending_mask;
  logic        err_underflow;
  logic        err_overflow;

  int cnt [NREG];
  bit m_uf;
  int n_checks = 0;
  int n_fail   = 0;

  reg_scoreboard dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_valid      (issue_valid),
    .issue_read_en    (issue_read_en),
    .issue_read_addr  (issue_read_addr),
    .issue_write_en   (issue_write_en),
    .issue_write_addr (issue_write_addr),
    .wb_en            (wb_en),
    .wb_addr          (wb_addr),
    .flush            (flush),
    .stall            (stall),
    .issue_fire       (issue_fire),
    .pending_mask     (pending_mask),
    .err_underflow    (err_underflow),
    .err_overflow     (err_overflow)
  );

  always #5 clk = ~clk;

  function automatic bit tracked(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREG);
  endfunction

  function automatic bit m_stall();
    bit hz = 1'b0;
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a = issue_read_addr[p*5 +: 5];
      if (issue_read_en[p] && tracked(a) && cnt[a] > 0) begin
        if (!(BYP && wb_en && wb_addr == a && cnt[a] == 1)) hz = 1'b1;
      end
    end
    if (issue_write_en && tracked(issue_write_addr) && cnt[issue_write_addr] == MAXC) hz = 1'b1;
    return issue_valid && hz;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] m = '0;
    for (int r = 0; r < NREG; r++) m[r] = (cnt[r] > 0);
    return m;
  endfunction

  task automatic idle();
    issue_valid = 0; issue_read_en = '0; issue_read_addr = '0;
    issue_write_en = 0; issue_write_addr = '0;
    wb_en = 0; wb_addr = '0; flush = 0;
  endtask

  task automatic set_read(input int p, input bit en, input logic [4:0] a);
    issue_read_en[p] = en;
    issue_read_addr[p*5 +: 5] = a;
  endtask

  task automatic set_write(input logic [4:0] a);
    issue_valid = 1; issue_write_en = 1; issue_write_addr = a;
  endtask

  // Advance one clock edge and move the model to its post-edge state.
  task automatic tick();
    int nxt [NREG];
    bit fire;
    bit uf;
    fire = issue_valid && !m_stall();
    nxt = cnt;
    uf = m_uf;
    if (flush) begin
      foreach (nxt[r]) nxt[r] = 0;
    end else begin
      if (wb_en && tracked(wb_addr)) begin
        if (cnt[wb_addr] == 0) uf = 1'b1;
        else nxt[wb_addr] = nxt[wb_addr] - 1;
      end
      if (fire && issue_write_en && tracked(issue_write_addr))
        nxt[issue_write_addr] = nxt[issue_write_addr] + 1;
    end
    @(posedge clk);
    #1;
    cnt = nxt;
    m_uf = uf;
  endtask

  task automatic model_clear();
    foreach (cnt[r]) cnt[r] = 0;
    m_uf = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    wb_en = 1; wb_addr = 5'd9; tick(); idle();
    set_write(5'd3); tick(); idle();
    set_write(5'd5); tick(); idle();
    #1;
    n_checks++;
    if (pending_mask !== 32'h28) begin n_fail++; $display("FAIL rst_pre_pending: got %h expected %h", pending_mask, 32'h28); end
    n_checks++;
    if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL rst_pre_uf: got %b expected 1", err_underflow); end
    #1;
    rst_n = 0;
    model_clear();
    #1;
    n_checks++;
    if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL rst_async_pending: got %h expected 0", pending_mask); end
    n_checks++;
    if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_err: got uf=%b of=%b expected 0 0", err_underflow, err_overflow);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    issue_valid = 1; set_read(0, 1, 5'd5);
    #1;
    n_checks++;
    if (stall !== 1'b0 || issue_fire !== 1'b1) begin
      n_fail++; $display("FAIL rst_read_r5: got stall=%b fire=%b expected 0 1", stall, issue_fire);
    end
    tick(); idle();
  endtask

  task automatic test_raw();
    apply_reset();
    set_write(5'd3);
    #1;
    n_checks++;
    if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL raw_fire_c0: got %b expected 1", issue_fire); end
    tick(); idle();
    issue_valid = 1; set_read(0, 1, 5'd3); wb_en = 1; wb_addr = 5'd3;
    #1;
    n_checks++;
    if (pending_mask[3] !== 1'b1) begin n_fail++; $display("FAIL raw_pending3: got %b expected 1", pending_mask[3]); end
    n_checks++;
    if (stall !== !BYP) begin n_fail++; $display("FAIL raw_stall_c1: got %b expected %b", stall, !BYP); end
    tick(); idle();
    issue_valid = 1; set_read(0, 1, 5'd3);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_stall_c2: got %b expected 0", stall); end
    tick(); idle();
  endtask

  task automatic test_waw();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      set_write(5'd7);
      #1;
      n_checks++;
      if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL waw_fire_%0d: got %b expected 1", k, issue_fire); end
      tick(); idle();
    end
    set_write(5'd7);
    #1;
    n_checks++;
    if (stall !== 1'b1 || issue_fire !== 1'b0) begin
      n_fail++; $display("FAIL waw_sat: got stall=%b fire=%b expected 1 0", stall, issue_fire);
    end
    tick();
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_sat_hold: got %b expected 1", stall); end
    idle();
    wb_en = 1; wb_addr = 5'd7; tick(); idle();
    set_write(5'd7); wb_en = 1; wb_addr = 5'd7;
    #1;
    n_checks++;
    if (stall !== 1'b0 || issue_fire !== 1'b1) begin
      n_fail++; $display("FAIL waw_same_cycle: got stall=%b fire=%b expected 0 1", stall, issue_fire);
    end
    tick(); idle();
    set_write(5'd7);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_count2: got stall=%b expected 0", stall); end
    tick(); idle();
    set_write(5'd7);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_count3: got stall=%b expected 1", stall); end
    idle();
    wb_en = 1; wb_addr = 5'd7; tick(); tick();
    n_checks++;
    if (pending_mask[7] !== 1'b1) begin n_fail++; $display("FAIL waw_drain2: got %b expected 1", pending_mask[7]); end
    tick(); idle();
    #1;
    n_checks++;
    if (pending_mask[7] !== 1'b0 || err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL waw_drain3: got pend=%b uf=%b expected 0 0", pending_mask[7], err_underflow);
    end
  endtask

  task automatic test_r0();
    apply_reset();
    set_write(5'd0);
    #1;
    n_checks++;
    if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL r0_write_fire: got %b expected 1", issue_fire); end
    tick(); idle();
    issue_valid = 1; set_read(0, 1, 5'd0); set_read(1, 1, 5'd0);
    #1;
    n_checks++;
    if (stall !== 1'b0 || pending_mask !== 32'h0) begin
      n_fail++; $display("FAIL r0_read: got stall=%b pend=%h expected 0 0", stall, pending_mask);
    end
    tick(); idle();
    wb_en = 1; wb_addr = 5'd0; tick(); idle();
    #1;
    n_checks++;
    if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL r0_wb_uf: got %b expected 0", err_underflow); end
  endtask

  task automatic test_underflow();
    apply_reset();
    wb_en = 1; wb_addr = 5'd9; tick(); idle();
    #1;
    n_checks++;
    if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b expected 1", err_underflow); end
    repeat (10) tick();
    n_checks++;
    if (err_underflow !== 1'b1 || pending_mask !== 32'h0) begin
      n_fail++; $display("FAIL uf_sticky: got uf=%b pend=%h expected 1 0", err_underflow, pending_mask);
    end
    set_write(5'd9); tick(); idle();
    set_write(5'd9); tick(); idle();
    set_write(5'd9);
    #1;
    n_checks++;
    if (pending_mask !== 32'h200 || stall !== 1'b0) begin
      n_fail++; $display("FAIL uf_count_zero: got pend=%h stall=%b expected 200 0", pending_mask, stall);
    end
    tick(); idle();
    set_write(5'd9);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL uf_count_three: got %b expected 1", stall); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    set_write(5'd2); tick(); idle();
    set_write(5'd4); tick(); idle();
    set_write(5'd6); tick(); idle();
    #1;
    n_checks++;
    if (pending_mask !== m_pending()) begin n_fail++; $display("FAIL flush_pre: got %h expected %h", pending_mask, m_pending()); end
    set_write(5'd8); flush = 1;
    #1;
    n_checks++;
    if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL flush_fire: got %b expected 1", issue_fire); end
    tick(); idle();
    #1;
    n_checks++;
    if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL flush_clear: got %h expected 0", pending_mask); end
    n_checks++;
    if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL flush_keep_err: got %b expected 1", err_underflow); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pend;
    bit          exp_stall;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 2; p++)
        set_read(p, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
      issue_write_en   = ($urandom_range(0, 2) != 0);
      issue_write_addr = 5'($urandom_range(0, 7));
      wb_en            = ($urandom_range(0, 2) == 0);
      wb_addr          = 5'($urandom_range(0, 7));
      flush            = ($urandom_range(0, 40) == 0);
      exp_stall = m_stall();
      exp_pend  = m_pending();
      #1;
      n_checks++;
      if (stall !== exp_stall || issue_fire !== (issue_valid && !exp_stall)) begin
        n_fail++; $display("FAIL rnd_stall[%0d]: got stall=%b fire=%b expected %b %b",
                           c, stall, issue_fire, exp_stall, issue_valid && !exp_stall);
      end
      n_checks++;
      if (pending_mask !== exp_pend) begin
        n_fail++; $display("FAIL rnd_pending[%0d]: got %h expected %h", c, pending_mask, exp_pend);
      end
      n_checks++;
      if (err_underflow !== m_uf || err_overflow !== 1'b0) begin
        n_fail++; $display("FAIL rnd_err[%0d]: got uf=%b of=%b expected %b 0", c, err_underflow, err_overflow, m_uf);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_clear();
    test_reset();
    test_raw();
    test_waw();
    test_r0();
    test_underflow();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the ID stage.
- Keeps a per-register count of in-flight writes and reserves the destination when an instruction issues.
- Releases a reservation at write-back.
- Raises a combinational stall when an enabled source read or the destination hits a busy entry.
- Successor to fixed 2-read/1-write address generation: any read-port count, multi-outstanding WAW tracking, flush, and error reporting.

Parameters:
- REG_ADDR_W, 5, register address width.
- REG_NUM, 32, number of architectural registers; must be <= 2**REG_ADDR_W.
- READ_PORTS, 2, number of source-operand ports checked per issue.
- CNT_W, 2, width of the per-register outstanding-write counter; max count is 2**CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  ID presents an instruction this cycle.
- issue_read_en  in  READ_PORTS  per-port source-read enable.
- issue_read_addr  in  READ_PORTS*REG_ADDR_W  packed source addresses; port i at [i*REG_ADDR_W +: REG_ADDR_W].
- issue_write_en  in  1  instruction writes a register.
- issue_write_addr  in  REG_ADDR_W  destination address.
- wb_en  in  1  write-back retires one write this cycle.
- wb_addr  in  REG_ADDR_W  retiring destination.
- flush  in  1  pipeline flush; all younger instructions are killed.
- stall  out  1  ID must hold; the instruction is not issued.
- issue_fire  out  1  issue_valid && !stall.
- pending_mask  out  REG_NUM  bit r = (count[r] != 0).
- err_underflow  out  1  sticky: wb_en to a register whose count is 0.
- err_overflow  out  1  sticky: an increment was attempted on a saturated count. This is unreachable while stall gating is correct.

Behaviour:
- Reset (rst_n low, asynchronous): all counts 0, pending_mask 0, err_underflow 0, err_overflow 0. stall then follows the combinational rule below (0 with idle inputs).
- Register 0 is never tracked: its count stays 0, reads of r0 never stall, and writes or write-backs to r0 are ignored with no error.
- Addresses >= REG_NUM are treated like r0.
- Read hazard, per port i: issue_read_en[i] && addr_i != 0 && count[addr_i] != 0.
- WAW saturation: issue_write_en && issue_write_addr != 0 && count[issue_write_addr] == MAX, where MAX = 2**CNT_W-1.
- stall = issue_valid && (any read hazard || WAW saturation). stall is purely combinational from current state and inputs, with zero-cycle latency.
- Increment: inc_r = issue_fire && issue_write_en && issue_write_addr == r.
- Decrement: dec_r = wb_en && wb_addr == r && count[r] != 0.
- Counter update on each rising clk edge:
  - inc only: count+1.
  - dec only: count-1.
  - inc and dec on the same register: count unchanged.
  - neither: hold.
- Issued writes take effect from the next cycle. A read in the same cycle as its own instruction's write does not see that write.
- wb_en with count 0: no change; err_underflow set.
- flush (synchronous, dominant): next-edge all counts cleared. Same-cycle issue and write-back are discarded. The error flags are kept.
- Sticky error flags are cleared only by reset.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Optional Feature:
- Macro: SCB_WB_BYPASS_EN.
- Defined: a read hazard on addr_i is suppressed when wb_en && wb_addr == addr_i && count[addr_i] == 1. The datapath forwards the write-back value in this case.
- Undefined: no suppression; the read stalls one extra cycle until the count reaches 0.
- Neither setting changes the WAW rule or the counter update.

Decomposition:
- Shared package/header (extend bus.v-style defines): REG_ADDR_W, REG_NUM, CNT_W defaults, and the r0 address constant.
- One sub-module, scb_counter: a single saturating up/down counter with clear, inc, dec, an underflow pulse and a nonzero flag, instantiated REG_NUM-1 times with a generate loop.
- Top level: hazard compare per read port, OR-reduction, and the sticky error flags.

Test Plan:
- Reset then idle:
  - Assert rst_n=0 mid-cycle with counts nonzero -> pending_mask=0 and errs=0 immediately.
  - Then issue a read of r5 -> stall=0.
- RAW stall:
  - Cycle 0: issue write r3 -> issue_fire=1.
  - Cycle 1: issue read port0=r3 -> stall=1, pending_mask[3]=1.
  - Cycle 1 wb r3 -> bypass off: stall=1 in cycle 1, 0 in cycle 2. Bypass on: stall=0 in cycle 1.
- WAW count (CNT_W=2):
  - Issue write r7 three times -> count 3.
  - Fourth write r7 -> stall=1 and count stays 3.
  - Same-cycle issue write r7 plus wb r7 -> count unchanged.
- r0 handling: issue write r0 then read r0 -> stall=0, pending_mask=0. wb r0 -> err_underflow stays 0.
- Underflow: wb_en r9 with count 0 -> err_underflow=1, still set 10 cycles later, count stays 0.
- Flush: counts on r2, r4 and r6, then flush together with an issued write to r8 -> next cycle pending_mask=0 and r8 not pending.
